stopwatch_counter: RTL
======================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: MAX_MINUTES, default 59, highest minute value counted (legal range 1..99).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 tick_10ms  input  1  single-cycle pulse, one per 10 ms, from the stopwatch clock divider.
REQ-005 start_stop  input  1  single-cycle debounced pulse; toggles counting.
REQ-006 clear  input  1  single-cycle debounced pulse; zeroes the count.
REQ-007 lap  input  1  single-cycle debounced pulse; freezes or releases the display.
REQ-008 digits  output  24  BCD display value: [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] cs tens, [3:0] cs ones.
REQ-009 running  output  1  high while state is RUN.
REQ-010 lap_active  output  1  high while the display is frozen.
REQ-011 ovf  output  1  high while state is OVF.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSE, OVF.
REQ-013 Transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSE; PAUSE+start_stop->RUN; PAUSE/OVF+clear->IDLE; RUN+tick at maximum->OVF; otherwise hold state.
REQ-014 clear SHALL be ignored in RUN; in IDLE it re-zeroes (no state change).
REQ-015 clear and start_stop in the same cycle in PAUSE: clear wins, next state IDLE.
REQ-016 start_stop SHALL be ignored in OVF.
REQ-017 The internal count SHALL increment by one centisecond on each clk edge where tick_10ms=1 and state=RUN; digits (when not frozen) reflect it on the following cycle.
REQ-018 tick_10ms and start_stop in the same RUN cycle: the tick is counted and the state goes to PAUSE.
REQ-019 Digit ranges: cs ones 0-9, cs tens 0-9, sec ones 0-9, sec tens 0-5, min ones 0-9, min tens 0-(MAX_MINUTES/10); each wrap to 0 carries into the next digit in the same cycle.
REQ-020 Minutes SHALL not exceed MAX_MINUTES (e.g. MAX_MINUTES=59: 59:59.99 is maximum).
REQ-021 A tick at the maximum count in RUN SHALL leave the count at maximum, enter OVF and assert ovf.
REQ-022 Ticks in IDLE, PAUSE and OVF SHALL be ignored.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, count 0, lap hold cleared.
REQ-025 Reset output values: digits=24'h000000, running=0, lap_active=0, ovf=0.
REQ-026 Reset asserted mid-count SHALL discard the count; after deassertion the first start_stop starts from 00:00.00.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN SHALL compile the lap-hold feature in or out.
REQ-028 With STOPWATCH_LAP_EN: lap in RUN with lap_active=0 latches the current count into a hold register and sets lap_active; lap with lap_active=1 (any state except IDLE) clears it; lap in IDLE ignored.
REQ-029 With STOPWATCH_LAP_EN: while lap_active=1 digits shows the hold register and the internal count keeps advancing; clear or entry to OVF clears lap_active.
REQ-030 Without STOPWATCH_LAP_EN: lap is ignored, lap_active is constant 0, no hold register exists, digits always shows the live count.

Verification
REQ-031 Reset, start_stop, 150 ticks -> digits=24'h000150, running=1.
REQ-032 Count at 00:59.99, one tick -> digits=24'h010000 one cycle later.
REQ-033 MAX_MINUTES=59, count at 59:59.99, one tick -> digits=24'h595999, ovf=1, running=0; further ticks/start_stop -> no change; clear -> 24'h000000, IDLE.
REQ-034 RUN at 00:00.09, tick and start_stop same cycle -> digits=24'h000010, running=0; 5 ticks -> unchanged; clear with start_stop -> IDLE, 24'h000000.
REQ-035 STOPWATCH_LAP_EN defined: RUN at 00:01.00, lap, 50 ticks -> digits=24'h000100, lap_active=1; lap -> digits=24'h000150, lap_active=0.
REQ-036 reset_n pulsed low at 00:12.34 in RUN -> all outputs reset values immediately, independent of clk.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch counter: BCD mm:ss.cc count with IDLE/RUN/PAUSE/OVF control FSM.
// Optional lap-hold display freeze is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_counter #(
   parameter int unsigned MAX_MINUTES = 59
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_10ms,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [23:0] digits,
   output logic        running,
   output logic        lap_active,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;

   localparam logic [3:0]  MIN_T_MAX = 4'(MAX_MINUTES / 10);
   localparam logic [3:0]  MIN_O_MAX = 4'(MAX_MINUTES % 10);
   localparam logic [23:0] MAX_COUNT = {MIN_T_MAX, MIN_O_MAX, 4'd5, 4'd9, 4'd9, 4'd9};

   state_t      state, state_next;
   logic [23:0] count, count_next;
   logic [23:0] shown;
   logic        at_max;
   logic        inc;
   logic        clear_count;

   assign at_max = (count == MAX_COUNT);

   always_comb begin
      state_next  = state;
      inc         = 1'b0;
      clear_count = 1'b0;
      case (state)
         IDLE: begin
            clear_count = clear;
            if (start_stop) state_next = RUN;
         end
         RUN: begin
            // A tick at the maximum count takes priority over start_stop.
            if (tick_10ms && at_max) begin
               state_next = OVF;
            end else begin
               inc = tick_10ms;
               if (start_stop) state_next = PAUSE;
            end
         end
         PAUSE: begin
            if (clear) begin
               clear_count = 1'b1;
               state_next  = IDLE;
            end else if (start_stop) begin
               state_next = RUN;
            end
         end
         OVF: begin
            if (clear) begin
               clear_count = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next = count;
      if (clear_count) begin
         count_next = '0;
      end else if (inc) begin
         if (count[3:0] != 4'd9) begin
            count_next[3:0] = count[3:0] + 4'd1;
         end else begin
            count_next[3:0] = '0;
            if (count[7:4] != 4'd9) begin
               count_next[7:4] = count[7:4] + 4'd1;
            end else begin
               count_next[7:4] = '0;
               if (count[11:8] != 4'd9) begin
                  count_next[11:8] = count[11:8] + 4'd1;
               end else begin
                  count_next[11:8] = '0;
                  if (count[15:12] != 4'd5) begin
                     count_next[15:12] = count[15:12] + 4'd1;
                  end else begin
                     count_next[15:12] = '0;
                     // Minutes never pass MAX_MINUTES here: inc is blocked at the maximum.
                     if (count[19:16] != 4'd9) begin
                        count_next[19:16] = count[19:16] + 4'd1;
                     end else begin
                        count_next[19:16] = '0;
                        count_next[23:20] = count[23:20] + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= '0;
         digits  <= '0;
         running <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         digits  <= shown;
         running <= (state_next == RUN);
         ovf     <= (state_next == OVF);
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [23:0] hold;
   logic        lap_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold  <= '0;
         lap_q <= 1'b0;
      end else if (clear_count || (state == RUN && state_next == OVF)) begin
         lap_q <= 1'b0;
      end else if (lap && lap_q && state != IDLE) begin
         lap_q <= 1'b0;
      end else if (lap && !lap_q && state == RUN) begin
         lap_q <= 1'b1;
         hold  <= count;
      end
   end

   assign lap_active = lap_q;
   assign shown      = lap_q ? hold : count;
`else
   logic unused_lap;

   assign unused_lap = lap;
   assign lap_active = 1'b0;
   assign shown      = count;
`endif

endmodule
